// File: rtl/divider_seq_ctrl.sv
// rtl/divider_seq_ctrl.sv - iterative unsigned restoring divider, one subtraction per clock
module divider_seq_ctrl #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  start_in,
    input  logic [DATA_WIDTH-1:0] dividend_in,
    input  logic [DATA_WIDTH-1:0] divisor_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [DATA_WIDTH-1:0] quotient_out,
    output logic [DATA_WIDTH-1:0] remainder_out,
    output logic                  div_by_zero_out
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(W);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [W-1:0]    rem_q;
    logic [W-1:0]    quo_q;
    logic [W-1:0]    divisor_q;
    logic [CW-1:0]   cnt_q;

    logic [W:0]      shifted;
    logic [W-1:0]    trial;
    logic            borrow;
    logic [W-1:0]    rem_nxt;
    logic [W-1:0]    quo_nxt;

    // Partial remainder is always below the divisor, so its W+1-bit form never
    // sets the top bit; the shifted value carries it only into the subtraction.
    always_comb begin
        shifted         = {rem_q, quo_q[W-1]};
        {borrow, trial} = shifted - {1'b0, divisor_q};
        rem_nxt         = borrow ? shifted[W-1:0] : trial;
        quo_nxt         = {quo_q[W-2:0], ~borrow};
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_out  = 1'b1;
        done_out  = 1'b0;
        case (state)
            ST_IDLE: begin
                busy_out = 1'b0;
                if (start_in) begin
                    state_nxt = (divisor_in == '0) ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done_out  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Result registers only change on entry to DONE.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rem_q           <= '0;
            quo_q           <= '0;
            divisor_q       <= '0;
            cnt_q           <= '0;
            quotient_out    <= '0;
            remainder_out   <= '0;
            div_by_zero_out <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_in) begin
                        quo_q     <= dividend_in;
                        divisor_q <= divisor_in;
                        rem_q     <= '0;
                        cnt_q     <= CNT_INIT;
                        if (divisor_in == '0) begin
                            quotient_out    <= '1;
                            remainder_out   <= dividend_in;
                            div_by_zero_out <= 1'b1;
                        end
                    end
                end
                ST_CALC: begin
                    rem_q <= rem_nxt;
                    quo_q <= quo_nxt;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        quotient_out    <= quo_nxt;
                        remainder_out   <= rem_nxt;
                        div_by_zero_out <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_divider_seq_ctrl.sv
// tb/tb_divider_seq_ctrl.sv - randomized self-checking bench for divider_seq_ctrl (W=4 and W=8)
module tb_divider_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start_any;
    logic       sel8;
    logic [7:0] a_drv;
    logic [7:0] b_drv;

    logic       start4, start8;
    logic       busy4, done4, dbz4;
    logic [3:0] q4, r4;
    logic       busy8, done8, dbz8;
    logic [7:0] q8, r8;

    logic       busy_sel, done_sel, dbz_sel;
    logic [7:0] q_sel, r_sel;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] prev_q [2];
    logic [7:0] prev_r [2];
    logic       prev_dbz [2];

    always #5 clk = ~clk;

    assign start4   = start_any & ~sel8;
    assign start8   = start_any & sel8;
    assign busy_sel = sel8 ? busy8 : busy4;
    assign done_sel = sel8 ? done8 : done4;
    assign dbz_sel  = sel8 ? dbz8 : dbz4;
    assign q_sel    = sel8 ? q8 : {4'b0, q4};
    assign r_sel    = sel8 ? r8 : {4'b0, r4};

    divider_seq_ctrl #(.DATA_WIDTH(4)) u_div4 (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (start4),
        .dividend_in     (a_drv[3:0]),
        .divisor_in      (b_drv[3:0]),
        .busy_out        (busy4),
        .done_out        (done4),
        .quotient_out    (q4),
        .remainder_out   (r4),
        .div_by_zero_out (dbz4)
    );

    divider_seq_ctrl #(.DATA_WIDTH(8)) u_div8 (
        .clk_in          (clk),
        .rst_in          (rst),
        .start_in        (start8),
        .dividend_in     (a_drv),
        .divisor_in      (b_drv),
        .busy_out        (busy8),
        .done_out        (done8),
        .quotient_out    (q8),
        .remainder_out   (r8),
        .div_by_zero_out (dbz8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One division on the selected instance; the first negedge is the idle cycle
    // following any previous DONE, so consecutive calls are back-to-back.
    task automatic run_op(input logic [7:0] a_in, input logic [7:0] b_in, input string tag);
        int         idx, w, lat, cycles, busy_cycles;
        logic [7:0] mask, a, b, eq, er;
        logic       ed;
        idx  = sel8 ? 1 : 0;
        w    = sel8 ? 8 : 4;
        mask = sel8 ? 8'hFF : 8'h0F;
        a    = a_in & mask;
        b    = b_in & mask;
        if (b == 0) begin
            eq = mask; er = a; ed = 1'b1; lat = 1;
        end else begin
            eq = a / b; er = a % b; ed = 1'b0; lat = w + 1;
        end
        @(negedge clk);
        check({tag, "_idle_busy"}, 32'(busy_sel), 32'd0);
        check({tag, "_idle_done"}, 32'(done_sel), 32'd0);
        a_drv     = a;
        b_drv     = b;
        start_any = 1'b1;
        @(negedge clk);
        start_any   = 1'b0;
        cycles      = 1;
        busy_cycles = 0;
        if (lat > 1) begin
            check({tag, "_hold_q"}, 32'(q_sel), 32'(prev_q[idx]));
            check({tag, "_hold_r"}, 32'(r_sel), 32'(prev_r[idx]));
            check({tag, "_hold_dbz"}, 32'(dbz_sel), 32'(prev_dbz[idx]));
        end
        while (1) begin
            if (busy_sel) busy_cycles++;
            if (done_sel || cycles >= 40) break;
            @(negedge clk);
            cycles++;
        end
        check({tag, "_done"}, 32'(done_sel), 32'd1);
        check({tag, "_latency"}, 32'(cycles), 32'(lat));
        check({tag, "_busy_cycles"}, 32'(busy_cycles), 32'(lat));
        check({tag, "_q"}, 32'(q_sel), 32'(eq));
        check({tag, "_r"}, 32'(r_sel), 32'(er));
        check({tag, "_dbz"}, 32'(dbz_sel), 32'(ed));
        prev_q[idx]   = eq;
        prev_r[idx]   = er;
        prev_dbz[idx] = ed;
    endtask

    initial begin
        int         pulses;
        logic [7:0] got_q, got_r;
        logic [7:0] ra, rb;
        rst       = 1'b1;
        start_any = 1'b0;
        sel8      = 1'b0;
        a_drv     = '0;
        b_drv     = '0;
        for (int i = 0; i < 2; i++) begin
            prev_q[i] = '0; prev_r[i] = '0; prev_dbz[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy4", 32'(busy4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        check("rst_q4", 32'(q4), 32'd0);
        check("rst_r4", 32'(r4), 32'd0);
        check("rst_dbz4", 32'(dbz4), 32'd0);
        check("rst_busy8", 32'(busy8), 32'd0);
        check("rst_q8", 32'(q8), 32'd0);
        check("rst_dbz8", 32'(dbz8), 32'd0);
        rst = 1'b0;

        run_op(8'd13, 8'd4, "w4_13_4");
        run_op(8'd15, 8'd1, "w4_15_1");
        run_op(8'd3, 8'd9, "w4_3_9");
        run_op(8'd9, 8'd9, "w4_9_9");
        run_op(8'd7, 8'd0, "w4_7_0");
        run_op(8'd6, 8'd3, "w4_6_3");

        // Second start during CALC must be dropped.
        @(negedge clk);
        a_drv = 8'd13; b_drv = 8'd4; start_any = 1'b1;
        @(negedge clk);
        start_any = 1'b0;
        @(negedge clk);
        a_drv = 8'd5; b_drv = 8'd2; start_any = 1'b1;
        @(negedge clk);
        start_any = 1'b0;
        pulses = 0; got_q = '0; got_r = '0;
        repeat (12) begin
            if (done_sel) begin
                pulses++;
                got_q = q_sel;
                got_r = r_sel;
            end
            @(negedge clk);
        end
        check("ign_pulses", 32'(pulses), 32'd1);
        check("ign_q", 32'(got_q), 32'd3);
        check("ign_r", 32'(got_r), 32'd1);
        prev_q[0] = 8'd3; prev_r[0] = 8'd1; prev_dbz[0] = 1'b0;

        // Reset in the second CALC cycle.
        a_drv = 8'd13; b_drv = 8'd4; start_any = 1'b1;
        @(negedge clk);
        start_any = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(busy4), 32'd0);
        check("mid_rst_done", 32'(done4), 32'd0);
        check("mid_rst_q", 32'(q4), 32'd0);
        check("mid_rst_r", 32'(r4), 32'd0);
        check("mid_rst_dbz", 32'(dbz4), 32'd0);
        rst    = 1'b0;
        pulses = 0;
        repeat (8) begin
            @(negedge clk);
            if (done_sel) pulses++;
        end
        check("mid_rst_no_done", 32'(pulses), 32'd0);
        prev_q[0] = '0; prev_r[0] = '0; prev_dbz[0] = 1'b0;
        run_op(8'd6, 8'd3, "w4_post_rst");

        sel8 = 1'b1;
        run_op(8'd255, 8'd16, "w8_255_16");
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom);
            run_op(ra, rb, "w8_rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
